mem_request_sequencer: RTL

- Sits directly upstream of the multi-core memory controller.
- Accepts one load or store command from the control unit, covering all SIMD cores. Snapshots each core's enable, address and data, then raises MRead or MWrite for the controller and waits for MReady.
- Captures the per-core read results and returns them to the core register files with a one-cycle done pulse.
- Holds the pipeline stall (busy) for the whole transaction and flags a hung controller with a timeout.

---
 rtl/mem_request_sequencer_pkg.sv | 29 ++
 rtl/mem_req_timeout_ctr.sv | 34 +++
 rtl/mem_request_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_request_sequencer_pkg.sv
// Shared constants and encodings for the memory request sequencer and the
// multi-core memory controller it feeds. Both sides import this package so
// the per-core lane widths and core count always agree.
package mem_request_sequencer_pkg;

  // Core count is derived from its log2 so the two can never disagree.
  localparam int N_CORES_LOG = 2;
  localparam int N_CORES     = 1 << N_CORES_LOG;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_t;

  // Width of a counter that must be able to hold the value 'limit'.
  function automatic int ctr_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_req_timeout_ctr.sv
// Wait-cycle counter for the sequencer. Cleared while the request is being
// issued, counts every enabled cycle, and flags the cycle that is the
// TIMEOUT-th one spent waiting so the FSM can give up on that same edge.
module mem_req_timeout_ctr
  import mem_request_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 255
)
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = ctr_width(TIMEOUT);

  logic [CNT_W-1:0] cnt_reg;

  // Counter saturates at the terminal value so a stalled enable never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && !tc) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tc = (cnt_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_request_sequencer.sv
// Memory request sequencer: takes one load/store command from the control
// unit for all SIMD cores, snapshots per-core enable/address/data, strobes
// the memory controller once, waits for MReady (or a timeout), and returns
// load results with a single-cycle done pulse. busy stalls the pipeline for
// the whole transaction. All outputs are registered.
module mem_request_sequencer
  import mem_request_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 255  // must be at least N_CORES + 2
)
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ld_req,
  input  logic                        st_req,
  input  logic [N_CORES-1:0]          core_en,
  input  logic [N_CORES*ADDR_W-1:0]   core_addr,
  input  logic [N_CORES*DATA_W-1:0]   core_data,
  output logic                        busy,
  output logic                        done,
  output logic [N_CORES-1:0]          wb_valid,
  output logic [N_CORES*DATA_W-1:0]   wb_data,
  output logic                        timeout_err,
  output logic                        proto_err,
  input  logic                        err_clr,
  output logic                        MRead,
  output logic                        MWrite,
  output logic [N_CORES-1:0]          en,
  output logic [N_CORES*ADDR_W-1:0]   in_addr,
  output logic [N_CORES*DATA_W-1:0]   in_data,
  input  logic                        MReady,
  input  logic [N_CORES*DATA_W-1:0]   q
);

  state_t state_reg, state_next;
  op_t    op_reg;

  logic                      busy_reg, busy_next;
  logic                      done_reg, done_next;
  logic                      mread_reg, mread_next;
  logic                      mwrite_reg, mwrite_next;
  logic [N_CORES-1:0]        wb_valid_reg, wb_valid_next;
  logic [N_CORES-1:0]        en_reg;
  logic [N_CORES*ADDR_W-1:0] addr_reg;
  logic [N_CORES*DATA_W-1:0] data_reg;
  logic [DATA_W-1:0]         wb_data_reg [N_CORES];
  logic                      timeout_err_reg;
  logic                      proto_err_reg;

  logic latch_req;
  logic capture;
  logic timeout_set;
  logic ctr_clr;
  logic ctr_en;
  logic ctr_tc;
  logic proto_set;

  mem_req_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk   (clk),
    .reset (reset),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .tc    (ctr_tc)
  );

  // A request is illegal if both kinds arrive together while idle, or if
  // any request arrives while a transaction is already in flight.
  assign proto_set = (state_reg == ST_IDLE) ? (ld_req & st_req)
                                            : (ld_req | st_req);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and next values for the registered outputs. Control
  // strobes and done are computed on the transition so they appear in the
  // cycle of the state they belong to. An empty mask still passes through
  // ISSUE, but without a controller strobe, which yields the two-cycle
  // request-to-done path for that case.
  always_comb begin
    state_next    = state_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    mread_next    = 1'b0;
    mwrite_next   = 1'b0;
    wb_valid_next = '0;
    latch_req     = 1'b0;
    capture       = 1'b0;
    timeout_set   = 1'b0;
    ctr_clr       = 1'b0;
    ctr_en        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ld_req ^ st_req) begin
          latch_req   = 1'b1;
          busy_next   = 1'b1;
          state_next  = ST_ISSUE;
          mread_next  = ld_req & (|core_en);
          mwrite_next = st_req & (|core_en);
        end
      end
      ST_ISSUE: begin
        ctr_clr = 1'b1;
        if (|en_reg) begin
          state_next = ST_WAIT;
        end else begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end
      end
      ST_WAIT: begin
        ctr_en = 1'b1;
        if (MReady) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
          if (op_reg == OP_LOAD) begin
            capture       = 1'b1;
            wb_valid_next = en_reg;
          end
        end else if (ctr_tc) begin
          state_next  = ST_DONE;
          done_next   = 1'b1;
          timeout_set = 1'b1;
        end
      end
      ST_DONE: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Registered control outputs and the request snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      mread_reg    <= 1'b0;
      mwrite_reg   <= 1'b0;
      wb_valid_reg <= '0;
      en_reg       <= '0;
      addr_reg     <= '0;
      data_reg     <= '0;
      op_reg       <= OP_LOAD;
    end else begin
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      mread_reg    <= mread_next;
      mwrite_reg   <= mwrite_next;
      wb_valid_reg <= wb_valid_next;
      if (latch_req) begin
        en_reg   <= core_en;
        addr_reg <= core_addr;
        data_reg <= core_data;
        op_reg   <= op_t'(st_req);
      end
    end
  end

  // Sticky error flags; a same-cycle clear wins over a new error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err_reg <= 1'b0;
      proto_err_reg   <= 1'b0;
    end else if (err_clr) begin
      timeout_err_reg <= 1'b0;
      proto_err_reg   <= 1'b0;
    end else begin
      if (timeout_set) timeout_err_reg <= 1'b1;
      if (proto_set)   proto_err_reg   <= 1'b1;
    end
  end

  // Per-core load result capture; disabled lanes keep their previous value.
  for (genvar gi = 0; gi < N_CORES; gi++) begin : g_wb_lane
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wb_data_reg[gi] <= '0;
      end else if (capture && en_reg[gi]) begin
        wb_data_reg[gi] <= q[gi*DATA_W +: DATA_W];
      end
    end
    assign wb_data[gi*DATA_W +: DATA_W] = wb_data_reg[gi];
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign wb_valid    = wb_valid_reg;
  assign timeout_err = timeout_err_reg;
  assign proto_err   = proto_err_reg;
  assign MRead       = mread_reg;
  assign MWrite      = mwrite_reg;
  assign en          = en_reg;
  assign in_addr     = addr_reg;
  assign in_data     = data_reg;

endmodule
